drive_sequencer: RTL and testbench
==================================

// Module: drive_sequencer
// PURPOSE
// - Top-level drive controller for the robot. Samples line sensors and the bumper,
//   and sequences the drive modes: follow, veer, junction crossing, collision recovery and lost-line search.
// - Emits per-motor direction and duty-percent commands.
// - Sits between sensor inputs and the PWM/H-bridge stage; owns all motion decisions.
// PARAMETERS
// - FULL_PERCENT     80           full-speed duty %; values above 80 clamp to 80 (H-bridge 2.5A stall limit)
// - VEER_PERCENT     40           slow-side / reverse / pivot / search duty %; same clamp
// - DEBOUNCE_CYCLES  50_000       consecutive bumper-high cycles that qualify a collision (1ms @50MHz)
// - BRAKE_CYCLES     5_000_000    cycles both motors coast after a collision
// - REVERSE_CYCLES   25_000_000   cycles both motors reverse
// - PIVOT_CYCLES     20_000_000   cycles of left-reverse/right-forward pivot
// - JUNCTION_CYCLES  10_000_000   cycles driven straight at full speed to cross a junction
// - SEARCH_CYCLES    100_000_000  lost-line search timeout
// - TIMER_W          27           phase-timer width; must hold the largest *_CYCLES value
// PORTS
// - clock           in   1  system clock, 50MHz
// - reset           in   1  synchronous, active-high
// - enable          in   1  run request; 0 forces IDLE
// - lineLeft        in   1  left line sensor, 1 = on line
// - lineCenter      in   1  centre line sensor
// - lineRight       in   1  right line sensor
// - collision       in   1  raw bumper, 1 = contact
// - leftDir         out  2  01 fwd (In1=0,In2=1), 10 rev, 00 coast
// - rightDir        out  2  same encoding (In3/In4)
// - leftDuty        out  7  duty percent, 0..80
// - rightDuty       out  7  duty percent, 0..80
// - driveState      out  3  current state code
// - junctionCount   out  8  junctions crossed; wraps 255->0
// BEHAVIOUR
// - All outputs are registered. Reset drives all outputs to 0, the state to IDLE, and clears timer, debounce and junctionCount.
// - Outputs reflect the new state one cycle after the input that caused the transition.
// - State codes: IDLE=0, FORWARD=1, BRAKE=2, REVERSE=3, PIVOT=4, JUNCTION=5, SEARCH=6, HALT=7.
// - Transition priority: reset > enable=0 (to IDLE from any state) > qualified collision > per-state rules.
// - Collision debounce:
//   - The counter increments while collision=1 and clears on collision=0.
//   - A collision qualifies on the cycle the counter reaches DEBOUNCE_CYCLES; the counter saturates there.
//   - A qualified collision in FORWARD, JUNCTION, SEARCH or PIVOT goes to BRAKE.
//   - It is ignored in BRAKE and REVERSE; HALT and IDLE also ignore it.
// - IDLE: Dir=00, Duty=0. Goes to FORWARD when enable=1.
// - FORWARD, with sensors {L,C,R}:
//   - 010: both fwd at FULL.
//   - 100/110: left VEER, right FULL.
//   - 001/011: left FULL, right VEER.
//   - 101: treated as 010.
//   - 111: go to JUNCTION and increment junctionCount.
//   - 000: see the optional feature below.
// - Timed states: the timer loads N-1 on entry and decrements; the state lasts exactly N cycles.
//   Entering a timed state from itself (PIVOT->BRAKE->...) reloads the timer.
//   - BRAKE: both 00, Duty 0; then REVERSE.
//   - REVERSE: both 10 at VEER; then PIVOT.
//   - PIVOT: left 10, right 01, both VEER; then FORWARD.
//   - JUNCTION: both 01 at FULL, sensors ignored; then FORWARD.
// - HALT: both 00, Duty 0. Left only via enable=0 -> IDLE.
// - Clamp: each duty = min(param, 80), computed at elaboration.
// - Reset mid-phase aborts immediately: next-cycle outputs are 0 and the state is IDLE.
// CONFIGURATION
// - LOST_LINE_SEARCH_EN defined:
//   - FORWARD + 000 -> SEARCH: left 01, right 10, both VEER (spin right).
//   - Any sensor nonzero -> FORWARD.
//   - Timer expiry after SEARCH_CYCLES -> HALT.
// - LOST_LINE_SEARCH_EN undefined:
//   - FORWARD + 000 -> HALT directly.
//   - The SEARCH state and code 6 are never entered.
// TESTING (override: DEBOUNCE=3, BRAKE=4, REVERSE=6, PIVOT=5, JUNCTION=8, SEARCH=20)
// - Reset held 2 cycles with enable=1 -> all outputs 0, driveState=0.
//   Release reset -> driveState=1 on the next cycle.
// - Sensors 010 -> Dir 01/01, Duty 80/80.
//   Sensors 100 -> leftDuty=40, rightDuty=80.
//   Sensors 001 -> leftDuty=80, rightDuty=40.
// - Bumper high 2 cycles then low -> no state change.
//   Bumper high 3 cycles -> BRAKE for 4 cycles, REVERSE 10/10 @40 for 6 cycles,
//   PIVOT 10/01 @40 for 5 cycles, then FORWARD.
// - Sensors 111 -> JUNCTION for 8 cycles, junctionCount 0->1; sensors 000 during crossing ignored.
//   255 junctions then one more -> junctionCount=0.
// - With LOST_LINE_SEARCH_EN: 000 for 20 cycles -> SEARCH then HALT (state 7).
//   000 then 010 at cycle 10 -> FORWARD.
//   Without the macro: 000 -> HALT on the next cycle.
// - enable=0 mid-REVERSE -> IDLE, Duty 0 next cycle.
//   Bumper qualifies on the same cycle as enable=0 -> IDLE.
//   Reset mid-PIVOT -> IDLE, all outputs 0.

Source files
------------

// File: rtl/drive_sequencer.sv
// drive_sequencer: top-level drive controller. Follows the line, veers to
// re-centre, crosses junctions, recovers from bumper hits (brake, reverse,
// pivot) and stops when the line is lost.
// Optional feature: define LOST_LINE_SEARCH_EN to spin in place looking for a
// lost line before halting. Without it, losing the line halts immediately.
module drive_sequencer #(
  parameter int FULL_PERCENT    = 80,
  parameter int VEER_PERCENT    = 40,
  parameter int DEBOUNCE_CYCLES = 50_000,
  parameter int BRAKE_CYCLES    = 5_000_000,
  parameter int REVERSE_CYCLES  = 25_000_000,
  parameter int PIVOT_CYCLES    = 20_000_000,
  parameter int JUNCTION_CYCLES = 10_000_000,
  parameter int SEARCH_CYCLES   = 100_000_000,
  parameter int TIMER_W         = 27
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       lineLeft,
  input  logic       lineCenter,
  input  logic       lineRight,
  input  logic       collision,
  output logic [1:0] leftDir,
  output logic [1:0] rightDir,
  output logic [6:0] leftDuty,
  output logic [6:0] rightDuty,
  output logic [2:0] driveState,
  output logic [7:0] junctionCount
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FORWARD  = 3'd1,
    ST_BRAKE    = 3'd2,
    ST_REVERSE  = 3'd3,
    ST_PIVOT    = 3'd4,
    ST_JUNCTION = 3'd5,
    ST_SEARCH   = 3'd6,
    ST_HALT     = 3'd7
  } state_t;

  // Duties are capped at 80% to keep the H-bridge under its stall current.
  localparam logic [6:0] FULL_DUTY = (FULL_PERCENT > 80) ? 7'd80 : 7'(FULL_PERCENT);
  localparam logic [6:0] VEER_DUTY = (VEER_PERCENT > 80) ? 7'd80 : 7'(VEER_PERCENT);

  localparam logic [1:0] DIR_COAST = 2'b00;
  localparam logic [1:0] DIR_FWD   = 2'b01;
  localparam logic [1:0] DIR_REV   = 2'b10;

  // Timed phases load N-1 so that the phase lasts exactly N cycles.
  localparam logic [TIMER_W-1:0] BRAKE_LOAD    = TIMER_W'(BRAKE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] REVERSE_LOAD  = TIMER_W'(REVERSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] PIVOT_LOAD    = TIMER_W'(PIVOT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] JUNCTION_LOAD = TIMER_W'(JUNCTION_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SEARCH_LOAD   = TIMER_W'(SEARCH_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DEB_LAST      = TIMER_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DEB_MAX       = TIMER_W'(DEBOUNCE_CYCLES);

  state_t              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [TIMER_W-1:0]  deb_q, deb_d;
  logic [7:0]          junction_q, junction_d;
  logic [1:0]          left_dir_q, left_dir_d;
  logic [1:0]          right_dir_q, right_dir_d;
  logic [6:0]          left_duty_q, left_duty_d;
  logic [6:0]          right_duty_q, right_duty_d;
  logic                coll_hit;
  logic                coll_state;
  logic                timer_done;
  logic [2:0]          sensors;

  assign sensors    = {lineLeft, lineCenter, lineRight};
  assign timer_done = (timer_q == '0);
  assign coll_state = (state_q == ST_FORWARD) || (state_q == ST_JUNCTION) ||
                      (state_q == ST_SEARCH)  || (state_q == ST_PIVOT);

  // Bumper debounce: qualifies once, on the cycle the run length reaches the threshold.
  always_comb begin
    deb_d    = deb_q;
    coll_hit = 1'b0;
    if (!collision) begin
      deb_d = '0;
    end else begin
      if (deb_q != DEB_MAX) deb_d = deb_q + 1'b1;
      coll_hit = (deb_q == DEB_LAST);
    end
  end

  // Next-state, phase timer and junction counter.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    junction_d = junction_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else if (coll_hit && coll_state) begin
      state_d = ST_BRAKE;
      timer_d = BRAKE_LOAD;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_FORWARD;
        ST_FORWARD: begin
          if (sensors == 3'b111) begin
            state_d    = ST_JUNCTION;
            timer_d    = JUNCTION_LOAD;
            junction_d = junction_q + 8'd1;
          end else if (sensors == 3'b000) begin
`ifdef LOST_LINE_SEARCH_EN
            state_d = ST_SEARCH;
            timer_d = SEARCH_LOAD;
`else
            state_d = ST_HALT;
`endif
          end
        end
        ST_BRAKE: begin
          if (timer_done) begin
            state_d = ST_REVERSE;
            timer_d = REVERSE_LOAD;
          end else timer_d = timer_q - 1'b1;
        end
        ST_REVERSE: begin
          if (timer_done) begin
            state_d = ST_PIVOT;
            timer_d = PIVOT_LOAD;
          end else timer_d = timer_q - 1'b1;
        end
        ST_PIVOT: begin
          if (timer_done) state_d = ST_FORWARD;
          else timer_d = timer_q - 1'b1;
        end
        ST_JUNCTION: begin
          if (timer_done) state_d = ST_FORWARD;
          else timer_d = timer_q - 1'b1;
        end
        ST_SEARCH: begin
          if (sensors != 3'b000) state_d = ST_FORWARD;
          else if (timer_done) state_d = ST_HALT;
          else timer_d = timer_q - 1'b1;
        end
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Motor commands for the state being entered, so outputs track state in the same cycle.
  always_comb begin
    left_dir_d   = DIR_COAST;
    right_dir_d  = DIR_COAST;
    left_duty_d  = 7'd0;
    right_duty_d = 7'd0;
    case (state_d)
      ST_FORWARD: begin
        left_dir_d   = DIR_FWD;
        right_dir_d  = DIR_FWD;
        left_duty_d  = FULL_DUTY;
        right_duty_d = FULL_DUTY;
        if (sensors == 3'b100 || sensors == 3'b110) left_duty_d = VEER_DUTY;
        if (sensors == 3'b001 || sensors == 3'b011) right_duty_d = VEER_DUTY;
      end
      ST_REVERSE: begin
        left_dir_d   = DIR_REV;
        right_dir_d  = DIR_REV;
        left_duty_d  = VEER_DUTY;
        right_duty_d = VEER_DUTY;
      end
      ST_PIVOT: begin
        left_dir_d   = DIR_REV;
        right_dir_d  = DIR_FWD;
        left_duty_d  = VEER_DUTY;
        right_duty_d = VEER_DUTY;
      end
      ST_JUNCTION: begin
        left_dir_d   = DIR_FWD;
        right_dir_d  = DIR_FWD;
        left_duty_d  = FULL_DUTY;
        right_duty_d = FULL_DUTY;
      end
      ST_SEARCH: begin
        left_dir_d   = DIR_FWD;
        right_dir_d  = DIR_REV;
        left_duty_d  = VEER_DUTY;
        right_duty_d = VEER_DUTY;
      end
      default: begin
        left_dir_d   = DIR_COAST;
        right_dir_d  = DIR_COAST;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      deb_q        <= '0;
      junction_q   <= '0;
      left_dir_q   <= DIR_COAST;
      right_dir_q  <= DIR_COAST;
      left_duty_q  <= 7'd0;
      right_duty_q <= 7'd0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      deb_q        <= deb_d;
      junction_q   <= junction_d;
      left_dir_q   <= left_dir_d;
      right_dir_q  <= right_dir_d;
      left_duty_q  <= left_duty_d;
      right_duty_q <= right_duty_d;
    end
  end

  assign leftDir       = left_dir_q;
  assign rightDir      = right_dir_q;
  assign leftDuty      = left_duty_q;
  assign rightDuty     = right_duty_q;
  assign driveState    = state_q;
  assign junctionCount = junction_q;

endmodule

// File: tb/tb_drive_sequencer.sv
// tb_drive_sequencer: scoreboard bench for drive_sequencer. A driver applies
// directed scenarios then random traffic, a reference model predicts the
// registered outputs after each clock, and a monitor compares them.
module tb_drive_sequencer;

  localparam int DEB  = 3;
  localparam int BRK  = 4;
  localparam int REV  = 6;
  localparam int PIV  = 5;
  localparam int JCT  = 8;
  localparam int SRCH = 20;
  localparam int FULL_REQ = 90;
  localparam int VEER_REQ = 40;

  localparam int M_IDLE = 0, M_FWD = 1, M_BRAKE = 2, M_REV = 3,
                 M_PIVOT = 4, M_JUNC = 5, M_SEARCH = 6, M_HALT = 7;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       lineLeft = 1'b0, lineCenter = 1'b0, lineRight = 1'b0;
  logic       collision = 1'b0;
  logic [1:0] leftDir, rightDir;
  logic [6:0] leftDuty, rightDuty;
  logic [2:0] driveState;
  logic [7:0] junctionCount;

  drive_sequencer #(
    .FULL_PERCENT(FULL_REQ), .VEER_PERCENT(VEER_REQ),
    .DEBOUNCE_CYCLES(DEB), .BRAKE_CYCLES(BRK), .REVERSE_CYCLES(REV),
    .PIVOT_CYCLES(PIV), .JUNCTION_CYCLES(JCT), .SEARCH_CYCLES(SRCH),
    .TIMER_W(8)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .lineLeft(lineLeft), .lineCenter(lineCenter), .lineRight(lineRight),
    .collision(collision),
    .leftDir(leftDir), .rightDir(rightDir),
    .leftDuty(leftDuty), .rightDuty(rightDuty),
    .driveState(driveState), .junctionCount(junctionCount)
  );

  always #5 clock = ~clock;

  typedef struct {
    int st;
    int ld;
    int rd;
    int lp;
    int rp;
    int jc;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;

  // Reference model: mode, cycles left in the current phase, bumper run length, junctions.
  int mMode = M_IDLE;
  int mLeft = 0;
  int mBumpRun = 0;
  int mJunc = 0;

  function automatic int clampDuty(input int p);
    return (p > 80) ? 80 : p;
  endfunction

  function automatic int phaseLength(input int m);
    case (m)
      M_BRAKE:  return BRK;
      M_REV:    return REV;
      M_PIVOT:  return PIV;
      M_JUNC:   return JCT;
      M_SEARCH: return SRCH;
      default:  return 0;
    endcase
  endfunction

  function automatic int phaseSuccessor(input int m);
    case (m)
      M_BRAKE: return M_REV;
      M_REV:   return M_PIVOT;
      default: return M_FWD;
    endcase
  endfunction

  task automatic enterMode(input int m);
    mMode = m;
    mLeft = phaseLength(m);
  endtask

  // Advance the model by one clock and return the outputs expected after it.
  task automatic modelStep(input bit rst, input bit en, input bit [2:0] s, input bit b,
                           output exp_t e);
    bit hit;
    if (rst) begin
      mMode = M_IDLE; mLeft = 0; mBumpRun = 0; mJunc = 0;
    end else begin
      mBumpRun = b ? mBumpRun + 1 : 0;
      hit = (mBumpRun == DEB);
      if (!en) enterMode(M_IDLE);
      else if (hit && (mMode == M_FWD || mMode == M_JUNC || mMode == M_SEARCH || mMode == M_PIVOT))
        enterMode(M_BRAKE);
      else if (mMode == M_IDLE) enterMode(M_FWD);
      else if (mMode == M_FWD) begin
        if (s == 3'b111) begin
          mJunc = (mJunc + 1) % 256;
          enterMode(M_JUNC);
        end else if (s == 3'b000) begin
`ifdef LOST_LINE_SEARCH_EN
          enterMode(M_SEARCH);
`else
          enterMode(M_HALT);
`endif
        end
      end else if (mMode == M_SEARCH && s != 3'b000) enterMode(M_FWD);
      else if (mMode != M_HALT) begin
        mLeft = mLeft - 1;
        if (mLeft == 0) enterMode(mMode == M_SEARCH ? M_HALT : phaseSuccessor(mMode));
      end
    end
    e.st = mMode; e.jc = mJunc;
    e.ld = 0; e.rd = 0; e.lp = 0; e.rp = 0;
    case (mMode)
      M_FWD: begin
        e.ld = 1; e.rd = 1;
        e.lp = (s == 3'b100 || s == 3'b110) ? clampDuty(VEER_REQ) : clampDuty(FULL_REQ);
        e.rp = (s == 3'b001 || s == 3'b011) ? clampDuty(VEER_REQ) : clampDuty(FULL_REQ);
      end
      M_REV:    begin e.ld = 2; e.rd = 2; e.lp = clampDuty(VEER_REQ); e.rp = clampDuty(VEER_REQ); end
      M_PIVOT:  begin e.ld = 2; e.rd = 1; e.lp = clampDuty(VEER_REQ); e.rp = clampDuty(VEER_REQ); end
      M_JUNC:   begin e.ld = 1; e.rd = 1; e.lp = clampDuty(FULL_REQ); e.rp = clampDuty(FULL_REQ); end
      M_SEARCH: begin e.ld = 1; e.rd = 2; e.lp = clampDuty(VEER_REQ); e.rp = clampDuty(VEER_REQ); end
      default: ;
    endcase
  endtask

  // Drive one cycle of inputs at the falling edge and queue the prediction.
  task automatic applyStimulus(input bit rst, input bit en, input bit [2:0] s, input bit b);
    exp_t e;
    @(negedge clock);
    reset = rst; enable = en;
    {lineLeft, lineCenter, lineRight} = s;
    collision = b;
    modelStep(rst, en, s, b, e);
    sb.push_back(e);
  endtask

  task automatic holdCycles(input int n, input bit en, input bit [2:0] s, input bit b);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, en, s, b);
  endtask

  task automatic checkField(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("driveState", int'(driveState), e.st);
    checkField("leftDir", int'(leftDir), e.ld);
    checkField("rightDir", int'(rightDir), e.rd);
    checkField("leftDuty", int'(leftDuty), e.lp);
    checkField("rightDuty", int'(rightDuty), e.rp);
    checkField("junctionCount", int'(junctionCount), e.jc);
  endtask

  // Monitor: compare registered outputs just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Driver: directed scenarios, then randomized traffic.
  initial begin
    int bumpHold;
    bit en;
    bit b;
    bit rst;
    bit [2:0] s;
    bit [2:0] sensorTable [8];
    sensorTable = '{3'b010, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};

    $display("[TB] reset and basic following");
    applyStimulus(1'b1, 1'b1, 3'b010, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'b010, 1'b0);
    holdCycles(3, 1'b1, 3'b010, 1'b0);
    holdCycles(2, 1'b1, 3'b100, 1'b0);
    holdCycles(2, 1'b1, 3'b001, 1'b0);
    holdCycles(1, 1'b1, 3'b110, 1'b0);
    holdCycles(1, 1'b1, 3'b011, 1'b0);
    holdCycles(1, 1'b1, 3'b101, 1'b0);

    $display("[TB] bumper debounce and recovery");
    holdCycles(2, 1'b1, 3'b010, 1'b1);
    holdCycles(3, 1'b1, 3'b010, 1'b0);
    holdCycles(3, 1'b1, 3'b010, 1'b1);
    holdCycles(BRK + REV + PIV + 3, 1'b1, 3'b010, 1'b0);

    $display("[TB] junction crossing and counter wrap");
    holdCycles(1, 1'b1, 3'b111, 1'b0);
    holdCycles(JCT - 1, 1'b1, 3'b000, 1'b0);
    holdCycles(2, 1'b1, 3'b010, 1'b0);
    for (int j = 0; j < 256; j++) begin
      holdCycles(1, 1'b1, 3'b111, 1'b0);
      holdCycles(JCT + 1, 1'b1, 3'b010, 1'b0);
    end

    $display("[TB] lost line");
    holdCycles(SRCH + 5, 1'b1, 3'b000, 1'b0);
    holdCycles(1, 1'b0, 3'b010, 1'b0);
    holdCycles(3, 1'b1, 3'b010, 1'b0);
    holdCycles(10, 1'b1, 3'b000, 1'b0);
    holdCycles(3, 1'b1, 3'b010, 1'b0);

    $display("[TB] enable drop and reset mid-phase");
    holdCycles(3, 1'b1, 3'b010, 1'b1);
    holdCycles(BRK + 2, 1'b1, 3'b010, 1'b0);
    holdCycles(1, 1'b0, 3'b010, 1'b0);
    holdCycles(3, 1'b1, 3'b010, 1'b0);
    holdCycles(2, 1'b1, 3'b010, 1'b1);
    holdCycles(1, 1'b0, 3'b010, 1'b1);
    holdCycles(3, 1'b1, 3'b010, 1'b0);
    holdCycles(3, 1'b1, 3'b010, 1'b1);
    holdCycles(BRK + REV + 2, 1'b1, 3'b010, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'b010, 1'b0);
    holdCycles(3, 1'b1, 3'b010, 1'b0);

    $display("[TB] random traffic");
    bumpHold = 0;
    for (int k = 0; k < 1500; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 39) != 0);
      s   = ($urandom_range(0, 15) == 0) ? 3'b000 : sensorTable[$urandom_range(0, 7)];
      if (bumpHold == 0 && $urandom_range(0, 29) == 0) bumpHold = $urandom_range(1, 5);
      b = (bumpHold != 0);
      if (bumpHold != 0) bumpHold--;
      applyStimulus(rst, en, s, b);
    end

    @(negedge clock);
    @(negedge clock);
    checkField("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
